// File: rtl/m_wb_mem_stage_pkg.sv
// rtl/m_wb_mem_stage_pkg.sv - shared types and constants for the MEM/WB stage
package m_wb_mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic half, input logic [1:0] addr_lo);
        return half ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/m_wb_mem_stage_if.sv
// rtl/m_wb_mem_stage_if.sv - data-memory request/acknowledge bus
interface m_wb_mem_stage_if #(
    parameter int addr_size = 16,
    parameter int data_size = 32
);
    logic                 DM_req;
    logic                 DM_we;
    logic [3:0]           DM_be;
    logic [addr_size-1:0] DM_addr;
    logic [data_size-1:0] DM_wdata;
    logic [data_size-1:0] DM_rdata;
    logic                 DM_ack;

    modport master (
        output DM_req, DM_we, DM_be, DM_addr, DM_wdata,
        input  DM_rdata, DM_ack
    );

    modport slave (
        input  DM_req, DM_we, DM_be, DM_addr, DM_wdata,
        output DM_rdata, DM_ack
    );
endinterface

// File: rtl/m_wb_load_align.sv
// rtl/m_wb_load_align.sv - load lane select with halfword sign extension
module m_wb_load_align #(
    parameter int data_size = 32
) (
    input  logic [data_size-1:0] rdata,
    input  logic                 half,
    input  logic                 hi_sel,
    output logic [data_size-1:0] data
);

    logic [15:0] lane;

    // Pick the addressed halfword and sign-extend it; words pass through.
    always_comb begin
        lane = hi_sel ? rdata[31:16] : rdata[15:0];
        data = rdata;
        if (half) begin
            data = {{(data_size-16){lane[15]}}, lane};
        end
    end

endmodule

// File: rtl/m_wb_mem_stage.sv
// rtl/m_wb_mem_stage.sv - MEM stage access control and M/WB pipeline register
module m_wb_mem_stage
    import m_wb_mem_stage_pkg::*;
#(
    parameter int pc_size   = 18,
    parameter int data_size = 32,
    parameter int addr_size = 16,
    parameter int timeout   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemtoReg,
    input  logic                 M_RegWrite,
    input  logic                 M_MemWrite,
    input  logic                 M_Jal,
    input  logic                 M_Half,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_Rt_data,
    input  logic [pc_size-1:0]   M_PCplus8,
    input  logic [4:0]           M_WR_out,
    m_wb_mem_stage_if.master     dm,
    output logic                 M_stall,
    output logic                 M_bus_err,
    output logic                 M_misalign,
    output logic                 WB_MemtoReg,
    output logic                 WB_RegWrite,
    output logic                 WB_Jal,
    output logic [data_size-1:0] WB_ALU_result,
    output logic [data_size-1:0] WB_DM_out,
    output logic [pc_size-1:0]   WB_PCplus8,
    output logic [4:0]           WB_WR_out
);

    localparam logic [7:0] TIMEOUT_C = 8'(timeout);

    mem_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 bus_err_q, bus_err_d;
    logic                 misalign_q, misalign_d;
    logic                 wb_m2r_q, wb_m2r_d;
    logic                 wb_rw_q, wb_rw_d;
    logic                 wb_jal_q, wb_jal_d;
    logic [data_size-1:0] wb_alu_q, wb_alu_d;
    logic [data_size-1:0] wb_dm_q, wb_dm_d;
    logic [pc_size-1:0]   wb_pc8_q, wb_pc8_d;
    logic [4:0]           wb_wr_q, wb_wr_d;

    logic                 memop, misaligned, timed_out, req;
    logic                 retire;
    logic [data_size-1:0] load_data;

    m_wb_load_align #(.data_size(data_size)) u_load_align (
        .rdata  (dm.DM_rdata),
        .half   (M_Half),
        .hi_sel (M_ALU_result[1]),
        .data   (load_data)
    );

    // Request decode and bus drive; the request is withdrawn in the cycle the
    // wait budget is exhausted so upstream is released on the error edge.
    always_comb begin
        memop       = M_MemWrite | M_MemtoReg;
        misaligned  = memop & is_misaligned(M_Half, M_ALU_result[1:0]);
        timed_out   = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_C);
        req         = ~rst & memop & ~misaligned & ~timed_out;
        dm.DM_req   = req;
        dm.DM_we    = M_MemWrite;
        dm.DM_addr  = M_ALU_result[addr_size+1:2];
        dm.DM_be    = ~M_Half ? BE_WORD : (M_ALU_result[1] ? BE_HI : BE_LO);
        dm.DM_wdata = M_Half ? {2{M_Rt_data[15:0]}} : M_Rt_data;
        M_stall     = req & ~dm.DM_ack;
    end

    // Next-state, wait counter and M/WB register contents.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        retire     = 1'b0;
        wb_m2r_d   = 1'b0;
        wb_rw_d    = 1'b0;
        wb_jal_d   = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_dm_d    = wb_dm_q;
        wb_pc8_d   = wb_pc8_q;
        wb_wr_d    = wb_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (!memop) begin
                    retire = 1'b1;
                end else if (misaligned) begin
                    misalign_d = 1'b1;
                end else if (dm.DM_ack) begin
                    retire = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            ST_WAIT: begin
                if (timed_out) begin
                    state_d   = ST_IDLE;
                    cnt_d     = 8'd0;
                    bus_err_d = 1'b1;
                end else if (dm.DM_ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    retire  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        if (retire) begin
            wb_m2r_d = M_MemtoReg;
            wb_rw_d  = M_RegWrite;
            wb_jal_d = M_Jal;
            wb_alu_d = M_ALU_result;
            wb_dm_d  = M_MemtoReg ? load_data : '0;
            wb_pc8_d = M_PCplus8;
            wb_wr_d  = M_WR_out;
        end
    end

    // Falling-edge pipeline register with asynchronous clear.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_jal_q   <= 1'b0;
            wb_alu_q   <= '0;
            wb_dm_q    <= '0;
            wb_pc8_q   <= '0;
            wb_wr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_jal_q   <= wb_jal_d;
            wb_alu_q   <= wb_alu_d;
            wb_dm_q    <= wb_dm_d;
            wb_pc8_q   <= wb_pc8_d;
            wb_wr_q    <= wb_wr_d;
        end
    end

    assign M_bus_err     = bus_err_q;
    assign M_misalign    = misalign_q;
    assign WB_MemtoReg   = wb_m2r_q;
    assign WB_RegWrite   = wb_rw_q;
    assign WB_Jal        = wb_jal_q;
    assign WB_ALU_result = wb_alu_q;
    assign WB_DM_out     = wb_dm_q;
    assign WB_PCplus8    = wb_pc8_q;
    assign WB_WR_out     = wb_wr_q;

endmodule
